// File: rtl/pattern_pkg.sv
// Shared constants and types for the radial-ring pattern generator:
// palette, background colour, motion mode encodings and ping-pong states.
package pattern_pkg;

    localparam logic [5:0] PALETTE [0:7] = '{
        6'b101101, 6'b101100, 6'b101000, 6'b001100,
        6'b001000, 6'b100100, 6'b010010, 6'b111111
    };

    localparam logic [5:0] BG_COLOUR = 6'b000001;

    typedef enum logic [1:0] {
        MODE_EXPAND   = 2'b00,
        MODE_CONTRACT = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_FREEZE   = 2'b11
    } mode_e;

    typedef enum logic {
        PP_OUT = 1'b0,
        PP_IN  = 1'b1
    } pp_state_e;

    function automatic logic [17:0] square9(input logic [8:0] v);
        return {9'd0, v} * {9'd0, v};
    endfunction

endpackage

// File: rtl/ripple_ring_gen_if.sv
// Pixel bus between the VGA timing generator and the ring pattern generator.
interface ripple_ring_gen_if;

    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       next_frame;
    logic [5:0] rgb;

    modport master (output x, output y, output active, output next_frame, input rgb);
    modport slave  (input x, input y, input active, input next_frame, output rgb);

endinterface

// File: rtl/ring_threshold_seq.sv
// Recomputes the squared ring radii one entry per cycle with a single 9x9
// squarer; the previous table stays visible until each entry is overwritten.
module ring_threshold_seq
    import pattern_pkg::*;
#(
    parameter int NUM_RINGS    = 5,
    parameter int RING_SPACING = 24
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [5:0]                  phase,
    output logic [NUM_RINGS-1:0][17:0]  thr
);

    logic [2:0]                  idx_q, idx_d;
    logic                        busy_q, busy_d;
    logic [8:0]                  base_q, base_d;
    logic [NUM_RINGS-1:0][17:0]  thr_q, thr_d;
    logic [8:0]                  radius;
    logic [17:0]                 radius_sq;

    // base_q tracks idx*S so the radius needs only an adder, not a multiplier
    assign radius    = {3'd0, phase} + base_q;
    assign radius_sq = square9(radius);

    always_comb begin
        busy_d = busy_q;
        idx_d  = idx_q;
        base_d = base_q;
        thr_d  = thr_q;
        if (busy_q) begin
            for (int k = 0; k < NUM_RINGS; k++) begin
                if (idx_q == 3'(k)) begin
                    thr_d[k] = radius_sq;
                end
            end
            idx_d  = idx_q + 3'd1;
            base_d = base_q + 9'(RING_SPACING);
            if (idx_q == 3'(NUM_RINGS - 1)) begin
                busy_d = 1'b0;
            end
        end
        if (start) begin
            busy_d = 1'b1;
            idx_d  = '0;
            base_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            idx_q  <= '0;
            base_q <= '0;
            for (int k = 0; k < NUM_RINGS; k++) begin
                thr_q[k] <= square9(9'(k * RING_SPACING));
            end
        end else begin
            busy_q <= busy_d;
            idx_q  <= idx_d;
            base_q <= base_d;
            thr_q  <= thr_d;
        end
    end

    assign thr = thr_q;

endmodule

// File: rtl/ripple_ring_gen.sv
// Concentric ring pattern generator: per-frame phase/palette/centre motion
// plus a 3-stage pixel pipeline classifying each pixel against ring radii.
module ripple_ring_gen
    import pattern_pkg::*;
#(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int NUM_RINGS    = 5,
    parameter int RING_SPACING = 24,
    parameter int X_MARGIN     = 160,
    parameter int Y_MARGIN     = 120
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pattern_enable,
    input  logic [11:0]       step_size,
    input  logic [1:0]        mode,
    input  logic              drift_enable,
    ripple_ring_gen_if.slave  pix
);

    localparam logic [9:0] X_LO = 10'(X_MARGIN);
    localparam logic [9:0] X_HI = 10'(H_ACTIVE - X_MARGIN);
    localparam logic [9:0] Y_LO = 10'(Y_MARGIN);
    localparam logic [9:0] Y_HI = 10'(V_ACTIVE - Y_MARGIN);

    mode_e      mode_sel;
    logic       frame_upd;
    logic [5:0] p_q, p_d;
    logic [2:0] off_q, off_d;
    logic [3:0] frac_q, frac_d;
    logic [2:0] wcnt_q, wcnt_d;
    pp_state_e  pp_state_q, pp_state_d;
    logic [9:0] cx_q, cx_d, cy_q, cy_d;
    logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;

    logic [4:0] frac_sum;
    logic [8:0] inc_raw;
    logic [5:0] inc;
    logic [6:0] p_sum;
    logic       wrap;
    logic       move_en, move_out;

    logic [9:0]  dx_q, dx_d, dy_q, dy_d;
    logic        act1_q, act2_q;
    logic [20:0] d2_q, d2_d;
    logic [5:0]  rgb_q, rgb_d;
    logic        ring_hit;
    logic [2:0]  ring_idx, pal_idx;
    logic [3:0]  pal_sum;

    logic [NUM_RINGS-1:0][17:0] thr;

    assign mode_sel  = mode_e'(mode);
    assign frame_upd = pattern_enable && pix.next_frame;

    assign frac_sum = {1'b0, frac_q} + {1'b0, step_size[3:0]};
    assign inc_raw  = {1'b0, step_size[11:4]} + {8'd0, frac_sum[4]};
    assign inc      = (inc_raw > 9'(RING_SPACING - 1)) ? 6'(RING_SPACING - 1) : inc_raw[5:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pp_state_q <= PP_OUT;
            wcnt_q     <= '0;
        end else begin
            pp_state_q <= pp_state_d;
            wcnt_q     <= wcnt_d;
        end
    end

    // The wrap that completes NUM_RINGS wraps flips the direction
    always_comb begin
        pp_state_d = pp_state_q;
        wcnt_d     = wcnt_q;
        if (frame_upd) begin
            if (mode_sel != MODE_PINGPONG) begin
                pp_state_d = PP_OUT;
                wcnt_d     = '0;
            end else if (wrap) begin
                if (wcnt_q == 3'(NUM_RINGS - 1)) begin
                    wcnt_d     = '0;
                    pp_state_d = (pp_state_q == PP_OUT) ? PP_IN : PP_OUT;
                end else begin
                    wcnt_d = wcnt_q + 3'd1;
                end
            end
        end
    end

    always_comb begin
        move_en  = 1'b1;
        move_out = 1'b1;
        case (mode_sel)
            MODE_EXPAND:   move_out = 1'b1;
            MODE_CONTRACT: move_out = 1'b0;
            MODE_PINGPONG: move_out = (pp_state_q == PP_OUT);
            default:       move_en  = 1'b0;
        endcase
    end

    always_comb begin
        p_d    = p_q;
        off_d  = off_q;
        frac_d = frac_q;
        wrap   = 1'b0;
        p_sum  = {1'b0, p_q} + {1'b0, inc};
        if (frame_upd && move_en) begin
            frac_d = frac_sum[3:0];
            if (move_out) begin
                if (p_sum >= 7'(RING_SPACING)) begin
                    p_d   = 6'(p_sum - 7'(RING_SPACING));
                    wrap  = 1'b1;
                    off_d = (off_q == 3'(NUM_RINGS - 1)) ? 3'd0 : off_q + 3'd1;
                end else begin
                    p_d = p_sum[5:0];
                end
            end else begin
                if (inc > p_q) begin
                    p_d   = 6'({1'b0, p_q} + 7'(RING_SPACING) - {1'b0, inc});
                    wrap  = 1'b1;
                    off_d = (off_q == 3'd0) ? 3'(NUM_RINGS - 1) : off_q - 3'd1;
                end else begin
                    p_d = p_q - inc;
                end
            end
        end
    end

    // Each axis steps onto its bound and turns around on that same frame
    always_comb begin
        cx_d    = cx_q;
        cy_d    = cy_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        if (frame_upd && drift_enable) begin
            cx_d = dir_x_q ? cx_q + 10'd1 : cx_q - 10'd1;
            cy_d = dir_y_q ? cy_q + 10'd1 : cy_q - 10'd1;
            if (dir_x_q && cx_d >= X_HI)       dir_x_d = 1'b0;
            else if (!dir_x_q && cx_d <= X_LO) dir_x_d = 1'b1;
            if (dir_y_q && cy_d >= Y_HI)       dir_y_d = 1'b0;
            else if (!dir_y_q && cy_d <= Y_LO) dir_y_d = 1'b1;
        end
    end

    always_comb begin
        dx_d = (pix.x >= cx_q) ? pix.x - cx_q : cx_q - pix.x;
        dy_d = (pix.y >= cy_q) ? pix.y - cy_q : cy_q - pix.y;
        d2_d = 21'({10'd0, dx_q} * {10'd0, dx_q}) + 21'({10'd0, dy_q} * {10'd0, dy_q});

        ring_hit = 1'b0;
        ring_idx = '0;
        for (int k = NUM_RINGS - 1; k >= 0; k--) begin
            if (d2_q <= {3'd0, thr[k]}) begin
                ring_hit = 1'b1;
                ring_idx = 3'(k);
            end
        end
        pal_sum = {1'b0, ring_idx} + 4'(NUM_RINGS) - {1'b0, off_q};
        pal_idx = (pal_sum >= 4'(NUM_RINGS)) ? 3'(pal_sum - 4'(NUM_RINGS)) : pal_sum[2:0];

        if (!act2_q)       rgb_d = '0;
        else if (ring_hit) rgb_d = PALETTE[pal_idx];
        else               rgb_d = BG_COLOUR;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_q     <= '0;
            off_q   <= '0;
            frac_q  <= '0;
            cx_q    <= 10'(H_ACTIVE / 2);
            cy_q    <= 10'(V_ACTIVE / 2);
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b1;
            dx_q    <= '0;
            dy_q    <= '0;
            act1_q  <= 1'b0;
            d2_q    <= '0;
            act2_q  <= 1'b0;
            rgb_q   <= '0;
        end else begin
            p_q     <= p_d;
            off_q   <= off_d;
            frac_q  <= frac_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            act1_q  <= pix.active;
            d2_q    <= d2_d;
            act2_q  <= act1_q;
            rgb_q   <= rgb_d;
        end
    end

    assign pix.rgb = rgb_q;

    ring_threshold_seq #(
        .NUM_RINGS    (NUM_RINGS),
        .RING_SPACING (RING_SPACING)
    ) u_seq (
        .clk   (clk),
        .rst_n (rst_n),
        .start (frame_upd),
        .phase (p_q),
        .thr   (thr)
    );

endmodule

// File: tb/tb_ripple_ring_gen.sv
// Directed bench for ripple_ring_gen: pixel vector table plus hand-written
// frame sequences for phase, ping-pong, drift and threshold sequencing.
module tb_ripple_ring_gen;
    import pattern_pkg::*;

    localparam int S = 24;
    localparam int N = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pattern_enable;
    logic [11:0] step_size;
    logic [1:0]  mode;
    logic        drift_enable;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       act;
        logic [5:0] rgb;
    } pix_vec_t;

    pix_vec_t vecs [0:10];

    ripple_ring_gen_if pix_if();

    ripple_ring_gen #(
        .H_ACTIVE(640), .V_ACTIVE(480), .NUM_RINGS(N), .RING_SPACING(S),
        .X_MARGIN(160), .Y_MARGIN(120)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pattern_enable (pattern_enable),
        .step_size      (step_size),
        .mode           (mode),
        .drift_enable   (drift_enable),
        .pix            (pix_if)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [9:0] px, input logic [9:0] py, input logic pact);
        @(negedge clk);
        pix_if.x      = px;
        pix_if.y      = py;
        pix_if.active = pact;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic frame_strobe();
        @(negedge clk);
        pix_if.next_frame = 1'b1;
        @(negedge clk);
        pix_if.next_frame = 1'b0;
        repeat (7) @(negedge clk);
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) frame_strobe();
    endtask

    task automatic check_thr_phase(input string name, input int p);
        for (int k = 0; k < N; k++) begin
            check_output($sformatf("%s[%0d]", name, k), 32'(dut.u_seq.thr_q[k]), 32'((p + k * S) * (p + k * S)));
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n             = 1'b0;
        pattern_enable    = 1'b1;
        step_size         = 12'h010;
        mode              = 2'b00;
        drift_enable      = 1'b0;
        pix_if.x          = 10'd0;
        pix_if.y          = 10'd0;
        pix_if.active     = 1'b0;
        pix_if.next_frame = 1'b0;

        vecs[0]  = '{10'd320, 10'd240, 1'b1, 6'b101101};
        vecs[1]  = '{10'd344, 10'd240, 1'b1, 6'b101100};
        vecs[2]  = '{10'd600, 10'd240, 1'b1, 6'b000001};
        vecs[3]  = '{10'd320, 10'd240, 1'b0, 6'b000000};
        vecs[4]  = '{10'd330, 10'd240, 1'b1, 6'b101100};
        vecs[5]  = '{10'd320, 10'd288, 1'b1, 6'b101000};
        vecs[6]  = '{10'd320, 10'd312, 1'b1, 6'b001100};
        vecs[7]  = '{10'd416, 10'd240, 1'b1, 6'b001000};
        vecs[8]  = '{10'd417, 10'd240, 1'b1, 6'b000001};
        vecs[9]  = '{10'd320, 10'd192, 1'b1, 6'b101000};
        vecs[10] = '{10'd300, 10'd225, 1'b1, 6'b101000};

        do_reset();
        check_output("reset_rgb", 32'(pix_if.rgb), 32'd0);
        check_output("reset_p", 32'(dut.p_q), 32'd0);
        check_output("reset_off", 32'(dut.off_q), 32'd0);
        check_output("reset_cx", 32'(dut.cx_q), 32'd320);
        check_output("reset_cy", 32'(dut.cy_q), 32'd240);
        check_thr_phase("reset_thr", 0);

        for (int i = 0; i <= 10; i++) begin
            apply_stimulus(vecs[i].x, vecs[i].y, vecs[i].act);
            check_output($sformatf("pix_vec[%0d]", i), 32'(pix_if.rgb), 32'(vecs[i].rgb));
        end

        // Pipeline latency: new pixel must not show before the third clock
        apply_stimulus(10'd600, 10'd240, 1'b1);
        @(negedge clk);
        pix_if.x = 10'd320;
        repeat (2) @(posedge clk);
        #1;
        check_output("latency_2clk", 32'(pix_if.rgb), 32'(BG_COLOUR));
        @(posedge clk);
        #1;
        check_output("latency_3clk", 32'(pix_if.rgb), 32'b101101);

        // Expand at inc=1: 23 frames, then the wrapping 24th by hand
        run_frames(23);
        check_output("expand_p23", 32'(dut.p_q), 32'd23);
        check_output("expand_off0", 32'(dut.off_q), 32'd0);
        @(negedge clk);
        pix_if.next_frame = 1'b1;
        @(posedge clk);
        #1;
        check_output("wrap_p", 32'(dut.p_q), 32'd0);
        check_output("wrap_off", 32'(dut.off_q), 32'd1);
        check_output("thr1_old", 32'(dut.u_seq.thr_q[1]), 32'd2209);
        @(negedge clk);
        pix_if.next_frame = 1'b0;
        repeat (N) @(posedge clk);
        #1;
        check_output("thr1_new", 32'(dut.u_seq.thr_q[1]), 32'd576);
        check_output("thr4_new", 32'(dut.u_seq.thr_q[4]), 32'd9216);
        apply_stimulus(10'd330, 10'd240, 1'b1);
        check_output("wrap_pixel", 32'(pix_if.rgb), 32'b101101);

        pattern_enable = 1'b0;
        run_frames(1);
        check_output("gated_p", 32'(dut.p_q), 32'd0);
        pattern_enable = 1'b1;

        step_size = 12'h008;
        run_frames(1);
        check_output("half_f1", 32'(dut.p_q), 32'd0);
        run_frames(1);
        check_output("half_f2", 32'(dut.p_q), 32'd1);
        run_frames(2);
        check_output("half_f4", 32'(dut.p_q), 32'd2);

        mode = 2'b11;
        run_frames(10);
        check_output("freeze_p", 32'(dut.p_q), 32'd2);
        check_output("freeze_off", 32'(dut.off_q), 32'd1);

        // Ping-pong: direction flips on the fifth wrap (frame 120)
        do_reset();
        mode      = 2'b10;
        step_size = 12'h010;
        run_frames(119);
        check_output("pp119_state", 32'(dut.pp_state_q), 32'(PP_OUT));
        check_output("pp119_p", 32'(dut.p_q), 32'd23);
        check_output("pp119_off", 32'(dut.off_q), 32'd4);
        run_frames(1);
        check_output("pp120_state", 32'(dut.pp_state_q), 32'(PP_IN));
        check_output("pp120_p", 32'(dut.p_q), 32'd0);
        check_output("pp120_off", 32'(dut.off_q), 32'd0);
        run_frames(1);
        check_output("pp121_p", 32'(dut.p_q), 32'd23);
        check_output("pp121_off", 32'(dut.off_q), 32'd4);
        run_frames(1);
        check_output("pp122_p", 32'(dut.p_q), 32'd22);

        // Drift with the phase frozen
        do_reset();
        mode         = 2'b11;
        drift_enable = 1'b1;
        run_frames(1);
        check_output("drift1_cx", 32'(dut.cx_q), 32'd321);
        check_output("drift1_cy", 32'(dut.cy_q), 32'd241);
        run_frames(119);
        check_output("drift120_cy", 32'(dut.cy_q), 32'd360);
        check_output("drift120_cx", 32'(dut.cx_q), 32'd440);
        run_frames(1);
        check_output("drift121_cy", 32'(dut.cy_q), 32'd359);
        run_frames(39);
        check_output("drift160_cx", 32'(dut.cx_q), 32'd480);
        run_frames(1);
        check_output("drift161_cx", 32'(dut.cx_q), 32'd479);
        check_output("drift161_cy", 32'(dut.cy_q), 32'd319);
        check_output("drift_frozen_p", 32'(dut.p_q), 32'd0);

        // Sequencer restart: two strobes two cycles apart at inc=5
        do_reset();
        drift_enable = 1'b0;
        mode         = 2'b00;
        step_size    = 12'h050;
        @(negedge clk);
        pix_if.next_frame = 1'b1;
        @(negedge clk);
        pix_if.next_frame = 1'b0;
        @(negedge clk);
        pix_if.next_frame = 1'b1;
        @(negedge clk);
        pix_if.next_frame = 1'b0;
        repeat (8) @(negedge clk);
        check_output("restart_p", 32'(dut.p_q), 32'd10);
        check_thr_phase("restart_thr", 10);
        apply_stimulus(10'd320, 10'd240, 1'b1);
        check_output("restart_pixel", 32'(pix_if.rgb), 32'b101101);

        // Reset arriving in the middle of a sequence
        @(negedge clk);
        pix_if.next_frame = 1'b1;
        @(negedge clk);
        pix_if.next_frame = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_thr_phase("midreset_thr", 0);
        check_output("midreset_rgb", 32'(pix_if.rgb), 32'd0);
        check_output("midreset_p", 32'(dut.p_q), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check_thr_phase("postreset_thr", 0);
        check_output("postreset_rgb", 32'(pix_if.rgb), 32'b101101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ripple_ring_gen.md
# ripple_ring_gen

Parametrised radial-ring pattern generator for the VGA pattern mux: draws `NUM_RINGS` concentric rings around a movable centre, with continuous expand, contract or ping-pong motion and palette rotation. It consumes the shared pixel coordinates and frame strobe, and drives a registered 6-bit colour three clocks after the pixel input. Ring radii squared are recomputed once per frame by a sequential single-squarer engine, so no per-ring multipliers are needed.

## Interface
- `H_ACTIVE`, 640: active width; reset centre x = `H_ACTIVE/2`.
- `V_ACTIVE`, 480: active height; reset centre y = `V_ACTIVE/2`.
- `NUM_RINGS`, 5: ring count, legal range 1..8.
- `RING_SPACING`, 24: radius step S between rings, legal range 2..64.
- `X_MARGIN`, 160 / `Y_MARGIN`, 120: drift keeps centre within [MARGIN, ACTIVE-MARGIN].
- `clk` in 1: pixel clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `pattern_enable` in 1: gates all per-frame state updates.
- `x`, `y` in 10 each: current pixel coordinate.
- `active` in 1: pixel is in the visible area.
- `next_frame` in 1: one-cycle frame strobe, asserted in blanking.
- `step_size` in 12: speed, 8.4 fixed point (integer part [11:4], fraction [3:0]).
- `mode` in 2: 00 expand, 01 contract, 10 ping-pong, 11 freeze.
- `drift_enable` in 1: centre bounces ±1 px per axis per frame.
- `rgb` out 6: colour, bit order {R1,G1,B1,R0,G0,B0}; registered.

## Operation
- Frame update fires when `pattern_enable && next_frame`; otherwise all state holds.
- Increment: inc = step_size[11:4] + carry(frac_acc + step_size[3:0]). frac_acc is 4 bits and keeps the sum mod 16. inc saturates at S-1.
- Phase p is in [0, S-1]. Palette offset `off` is in [0, N-1].
- Expand: p += inc. If the result is ≥ S, subtract S and set off = (off+1) mod N (a "wrap").
- Contract: p −= inc. On underflow, add S and set off = (off+N−1) mod N (a wrap).
- Ping-pong: FSM with states OUT (behaves as expand) and IN (behaves as contract), plus a wrap counter `wcnt`.
  - Each wrap increments `wcnt`.
  - On the wrap that brings `wcnt` to N, the FSM toggles state and clears `wcnt`. That wrap's p/off update still applies.
  - `wcnt` clears and the FSM forces OUT whenever mode ≠ 10.
- Freeze: p, off and frac_acc hold.
- Drift is independent of mode. When `drift_enable` is high, cx and cy each step ±1. An axis direction reverses on the frame its coordinate reaches a bound; that frame's step moves onto the bound value. When `drift_enable` is low, the centre holds.
- Ring k radius r_k = p + k·S. thr[k] = r_k², 18 bits.
- Pixel classification:
  - d² = (x−cx)² + (y−cy)², 21 bits unsigned.
  - Ring index k = smallest k with d² ≤ thr[k] (the comparison is inclusive).
  - Colour = PALETTE[(k + N − off) mod N].
  - If no ring matches: BG = 6'b000001.
- rgb = 0 whenever the delayed `active` is low.

## Timing
- Reset values: rgb=0, p=0, off=0, frac_acc=0, FSM=OUT, wcnt=0, cx=H_ACTIVE/2, cy=V_ACTIVE/2, drift directions +x/+y. thr[k] = (k·S)² for all k; this table is reset-loaded, not computed.
- State update happens in the same cycle as qualified `next_frame`.
- Threshold sequencer:
  - Starts the cycle after the update and writes thr[0..N−1], one entry per cycle.
  - Busy for N cycles; the old table is used until each entry is overwritten.
  - A new qualified `next_frame` while busy restarts the sequence from thr[0] with the new p.
- Pixel pipeline latency is 3 clocks:
  - S1 registers dx, dy (absolute), and `active`.
  - S2 registers d².
  - S3 compares and registers `rgb`.
- A mode change takes effect at the next qualified `next_frame`.
- Reset mid-sequence aborts the sequencer and loads the reset table.

## Structure
- Package `pattern_pkg` holds:
  - the 8-entry PALETTE: 101101, 101100, 101000, 001100, 001000, 100100, 010010, 111111;
  - the BG constant;
  - the mode encodings;
  - the ping-pong state enum.
- Sub-module `ring_threshold_seq` contains the counter, the single 9×9 squarer and the thr register file with a busy flag.
- The top level holds the phase/drift/FSM logic and the pixel pipeline.

## Test plan
- Reset (S=24, N=5), mode 00, step_size=12'h010, pixel (320,240) active → rgb=101101 at +3 clocks. Pixel (344,240), d²=576 → 101100. Pixel (600,240) → 000001. `active`=0 → rgb=0.
- 24 frames in expand at inc=1 → p wraps to 0 and off=1. Pixel (330,240) → ring 1, palette index 0 → 101101. thr[1] reads 576 exactly N cycles after the strobe.
- step_size=12'h008 → p increments every second frame (p=1 after frame 2, p=2 after frame 4). Mode 11 → p stays constant over 10 frames.
- Mode 10 at inc=1 → FSM switches to IN at frame 120 (the 5th wrap); afterwards p decreases and off decrements on each underflow.
- drift_enable=1 → after 1 frame centre=(321,241). cx reaches 480 at frame 160 and is 479 at frame 161. cy reaches 360 at frame 120 and then reverses.
- Two qualified `next_frame` strobes 2 cycles apart → sequencer restarts, and thr matches the second p. Assert `rst_n`=0 mid-sequence → thr returns to (k·24)² and rgb=0.
